spi_flash_responder: RTL and testbench

//  SPI mode-0 flash responder (slave) that stands in for the external QSPI flash on the CPU's boot bus.
//  It answers the CPU's single-I/O READ (0x03), JEDEC ID (0x9F), deep power-down (0xB9) and wake (0xAB) commands.

---
 rtl/spi_flash_responder_pkg.sv | 23 ++
 rtl/spi_flash_responder_sync.sv | 25 ++
 rtl/spi_flash_responder.sv | 129 ++++++++++++
 tb/tb_spi_flash_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
// spi_flash_responder_pkg: opcodes, FSM states and JEDEC byte selection shared by the flash responder
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_PD   = 8'hB9;
    localparam logic [7:0] CMD_RPD  = 8'hAB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_t;

    // ID bytes go out MSB byte first; anything past the third byte reads as zero
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// spi_in_sync: 2-flop synchroniser with a third flop for rise/fall strobes
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // shift the async pin through the synchroniser chain
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) sr <= {3{RST_VAL}};
        else sr <= {sr[1:0], d};
    end

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash stand-in serving READ, JEDEC ID and power-down from a loader-filled RAM
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018,
    parameter logic        PUP_DOWN = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              spi_sclk,
    input  logic              spi_csb,
    input  logic              spi_d0,
    output logic              spi_d1,
    output logic              spi_d1_oe,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              sel,
    output logic              pdown,
    output logic [7:0]        last_cmd
);

    logic unused_sclk_q, sclk_rise, sclk_fall;
    logic csb_q, csb_rise, csb_fall;
    logic d0_q, unused_d0_rise, unused_d0_fall;

    spi_in_sync #(.RST_VAL(1'b0)) u_sclk (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .d(spi_sclk),
        .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    // csb idles high so a reset never looks like a deselect or an active transaction
    spi_in_sync #(.RST_VAL(1'b1)) u_csb (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .d(spi_csb),
        .q(csb_q), .rise(csb_rise), .fall(csb_fall)
    );

    spi_in_sync #(.RST_VAL(1'b0)) u_d0 (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .d(spi_d0),
        .q(d0_q), .rise(unused_d0_rise), .fall(unused_d0_fall)
    );

    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] addr;
    state_t            state;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [6:0]        shin;
    logic [6:0]        shout;
    logic [7:0]        opcode;
    logic [7:0]        nxt;

    assign sel    = ~csb_q;
    assign opcode = {shin, d0_q};
    assign nxt    = state == ST_DATA ? rd_data : id_byte(JEDEC_ID, byte_cnt);

    // loader write port and continuous read of the current address; same-address collisions return the old byte
    always_ff @(posedge sys_clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        rd_data <= mem[addr];
    end

    // transaction FSM: command decode, address capture and MISO shifting
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state     <= ST_IDLE;
            spi_d1    <= 1'b0;
            spi_d1_oe <= 1'b0;
            pdown     <= PUP_DOWN;
            last_cmd  <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shin      <= 7'd0;
            shout     <= 7'd0;
            addr      <= '0;
        end else if (csb_rise) begin
            state     <= ST_IDLE;
            spi_d1    <= 1'b0;
            spi_d1_oe <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: if (csb_fall) begin
                    state    <= ST_CMD;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 2'd0;
                end
                ST_CMD: if (sclk_rise) begin
                    shin    <= opcode[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        last_cmd <= opcode;
                        state    <= pdown ? ST_IGNORE : opcode == CMD_READ ? ST_ADDR :
                                    opcode == CMD_RDID ? ST_ID : ST_IGNORE;
                        if (opcode == CMD_RPD) pdown <= 1'b0;
                        else if (!pdown && opcode == CMD_PD) pdown <= 1'b1;
                    end
                end
                ST_ADDR: if (sclk_rise) begin
                    addr    <= {addr[ADDR_W-2:0], d0_q};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= byte_cnt == 2'd2 ? 2'd0 : byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) state <= ST_DATA;
                    end
                end
                ST_DATA, ST_ID: if (sclk_fall) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd0) begin
                        shout     <= nxt[6:0];
                        spi_d1    <= nxt[7];
                        spi_d1_oe <= 1'b1;
                        if (state == ST_DATA) addr <= addr + ADDR_W'(1);
                        else byte_cnt <= byte_cnt == 2'd3 ? 2'd3 : byte_cnt + 2'd1;
                    end else begin
                        shout  <= {shout[5:0], 1'b0};
                        spi_d1 <= shout[6];
                    end
                end
                ST_IGNORE: spi_d1_oe <= 1'b0;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI transactions with a queue-based MISO scoreboard
module tb_spi_flash_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_csb = 1'b1;
    logic        spi_d0 = 1'b0;
    logic        spi_d1, spi_d1_oe;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = 12'd0;
    logic [7:0]  ld_data = 8'd0;
    logic        sel, pdown;
    logic [7:0]  last_cmd;

    int checks = 0;
    int failures = 0;

    // kind 0: byte not checked, 1: must be driven with data, 2: must not be driven
    typedef struct {
        logic [7:0] data;
        int         kind;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    spi_flash_responder #(.ADDR_W(12), .JEDEC_ID(24'hEF4018), .PUP_DOWN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .spi_sclk(spi_sclk), .spi_csb(spi_csb),
        .spi_d0(spi_d0), .spi_d1(spi_d1), .spi_d1_oe(spi_d1_oe), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .sel(sel), .pdown(pdown), .last_cmd(last_cmd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: assemble MISO bytes sampled just before each sclk rise and score them
    logic [7:0] m_sh = 8'd0;
    logic       m_oe_all = 1'b1;
    logic       m_oe_any = 1'b0;
    int         m_cnt = 0;

    always @(posedge spi_sclk or negedge spi_csb) begin
        if (spi_sclk === 1'b1) begin
            if (m_cnt == 0) begin
                m_oe_all = 1'b1;
                m_oe_any = 1'b0;
            end
            m_sh = {m_sh[6:0], spi_d1};
            m_oe_all = m_oe_all & spi_d1_oe;
            m_oe_any = m_oe_any | spi_d1_oe;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL monitor_unexpected_byte actual=%0h required=none", m_sh);
                end else begin
                    e = q.pop_front();
                    if (e.kind == 1) check(e.name, {23'd0, m_oe_all, m_sh}, {23'd0, 1'b1, e.data});
                    else if (e.kind == 2) check(e.name, {31'd0, m_oe_any}, 32'd0);
                end
            end
        end else m_cnt = 0;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic bits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            spi_d0 = tx[7-i];
            clk_n(4);
            spi_sclk = 1'b1;
            clk_n(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int kind, input logic [7:0] exp, input string nm);
        q.push_back('{data: exp, kind: kind, name: nm});
        bits(tx, 8);
    endtask

    task automatic cs_lo();
        clk_n(1);
        spi_csb = 1'b0;
        clk_n(4);
    endtask

    task automatic cs_hi();
        clk_n(4);
        spi_csb = 1'b1;
        clk_n(8);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
        xfer(op, 0, 8'h00, "cmd");
        xfer(a[23:16], 0, 8'h00, "a2");
        xfer(a[15:8], 0, 8'h00, "a1");
        xfer(a[7:0], 0, 8'h00, "a0");
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        @(negedge sys_clk);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge sys_clk);
        ld_we = 1'b0;
    endtask

    initial begin
        clk_n(3);
        check("rst_d1", {31'd0, spi_d1}, 32'd0);
        check("rst_oe", {31'd0, spi_d1_oe}, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_pdown", {31'd0, pdown}, 32'd1);
        check("rst_last_cmd", {24'd0, last_cmd}, 32'h00);
        sys_rstn = 1'b1;
        clk_n(2);

        cs_lo();
        cmd_addr(8'h03, 24'h000000);
        xfer(8'h00, 2, 8'h00, "pd_read_no_drive");
        cs_hi();
        check("pd_read_last_cmd", {24'd0, last_cmd}, 32'h03);
        check("pd_read_pdown", {31'd0, pdown}, 32'd1);
        cs_lo();
        xfer(8'hAB, 0, 8'h00, "wake");
        cs_hi();
        check("wake_pdown", {31'd0, pdown}, 32'd0);
        check("wake_last_cmd", {24'd0, last_cmd}, 32'hAB);

        for (int i = 0; i < 16; i++) load(12'(i), 8'(i));
        load(12'hFFE, 8'hFE);
        load(12'hFFF, 8'hFF);
        cs_lo();
        cmd_addr(8'h03, 24'h000004);
        for (int i = 0; i < 4; i++) xfer(8'h00, 1, 8'(4 + i), "read4");
        check("sel_active", {31'd0, sel}, 32'd1);
        cs_hi();
        check("sel_idle", {31'd0, sel}, 32'd0);
        check("read4_last_cmd", {24'd0, last_cmd}, 32'h03);

        cs_lo();
        cmd_addr(8'h03, 24'h100FFE);
        xfer(8'h00, 1, 8'hFE, "wrap_ffe");
        xfer(8'h00, 1, 8'hFF, "wrap_fff");
        xfer(8'h00, 1, 8'h00, "wrap_000");
        xfer(8'h00, 1, 8'h01, "wrap_001");
        cs_hi();

        cs_lo();
        xfer(8'h9F, 0, 8'h00, "cmd");
        xfer(8'h00, 1, 8'hEF, "id0");
        xfer(8'h00, 1, 8'h40, "id1");
        xfer(8'h00, 1, 8'h18, "id2");
        xfer(8'h00, 1, 8'h00, "id3_zero");
        cs_hi();
        check("id_last_cmd", {24'd0, last_cmd}, 32'h9F);
        cs_lo();
        xfer(8'hB9, 0, 8'h00, "cmd");
        cs_hi();
        check("pd_set", {31'd0, pdown}, 32'd1);
        cs_lo();
        xfer(8'h9F, 0, 8'h00, "cmd");
        for (int i = 0; i < 3; i++) xfer(8'h00, 2, 8'h00, "pd_id_no_drive");
        cs_hi();
        check("pd_id_pdown", {31'd0, pdown}, 32'd1);
        cs_lo();
        xfer(8'hAB, 0, 8'h00, "wake");
        cs_hi();
        check("wake2_pdown", {31'd0, pdown}, 32'd0);

        cs_lo();
        cmd_addr(8'h03, 24'h000FFE);
        xfer(8'h00, 1, 8'hFE, "abort_byte0");
        bits(8'h00, 3);
        check("abort_oe_before", {31'd0, spi_d1_oe}, 32'd1);
        check("abort_d1_before", {31'd0, spi_d1}, 32'd1);
        spi_csb = 1'b1;
        clk_n(4);
        check("abort_oe_after", {31'd0, spi_d1_oe}, 32'd0);
        check("abort_d1_after", {31'd0, spi_d1}, 32'd0);
        clk_n(4);
        cs_lo();
        cmd_addr(8'h03, 24'h000000);
        xfer(8'h00, 1, 8'h00, "reread_000");
        cs_hi();
        check("reread_last_cmd", {24'd0, last_cmd}, 32'h03);

        cs_lo();
        xfer(8'h03, 0, 8'h00, "cmd");
        xfer(8'h00, 0, 8'h00, "a2");
        @(negedge sys_clk);
        sys_rstn = 1'b0;
        @(negedge sys_clk);
        check("midrst_d1", {31'd0, spi_d1}, 32'd0);
        check("midrst_oe", {31'd0, spi_d1_oe}, 32'd0);
        check("midrst_sel", {31'd0, sel}, 32'd0);
        check("midrst_pdown", {31'd0, pdown}, 32'd1);
        check("midrst_last_cmd", {24'd0, last_cmd}, 32'h00);
        sys_rstn = 1'b1;
        clk_n(2);
        cs_hi();
        cs_lo();
        xfer(8'hAB, 0, 8'h00, "wake");
        cs_hi();
        check("post_rst_pdown", {31'd0, pdown}, 32'd0);
        cs_lo();
        cmd_addr(8'h03, 24'h000008);
        q.push_back('{data: 8'h08, kind: 1, name: "rdw_old"});
        bits(8'h00, 3);
        load(12'h008, 8'hA5);
        bits(8'h00, 5);
        xfer(8'h00, 1, 8'h09, "rdw_next");
        cs_hi();
        cs_lo();
        cmd_addr(8'h03, 24'h000008);
        xfer(8'h00, 1, 8'hA5, "rdw_new");
        cs_hi();
        check("post_rst_last_cmd", {24'd0, last_cmd}, 32'h03);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge sys_clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
